otter_cu_fsm_mc: RTL and testbench

Multicycle OTTER control FSM and the next generation of the current CU FSM. It adds a variable-latency memory handshake, replacing the fixed one-cycle fetch/load/store. It also supports NUM_IRQ masked interrupt sources with fixed priority, a cause output and per-source acknowledge. It sits between the IR decode fields, the memory interface and the CSR file; it sequences PC, register-file, memory and CSR write enables.

---
 rtl/otter_cu_pkg.sv | 44 ++++
 rtl/otter_irq_arbiter.sv | 68 ++++++
 rtl/otter_cu_fsm_mc.sv | 130 +++++++++++++
 tb/tb_otter_cu_fsm_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/otter_cu_pkg.sv
// Shared encodings for the multicycle OTTER control unit: RV32I major opcodes,
// SYSTEM funct3 values, FSM states and the MRET immediate.
package otter_cu_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_RSVD   = 3'b100,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_INTER
  } cu_state_t;

  localparam logic [11:0] MRET_FUNC12 = 12'h302;

  // Every SYSTEM funct3 except the privileged group and the reserved slot is a CSR op
  function automatic logic is_csr_op(input logic [2:0] f3);
    return (f3 != F3_PRIV) && (f3 != F3_RSVD);
  endfunction

endpackage

// File: rtl/otter_irq_arbiter.sv
// Interrupt front end: optional 2-flop synchronizer, sticky pending register,
// fixed-priority encoder (index 0 wins) and latched cause / one-hot acknowledge.
module otter_irq_arbiter
  import otter_cu_pkg::*;
#(
  parameter int NUM_IRQ  = 4,
  parameter int SYNC_IRQ = 1,
  localparam int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] imask,
  input  logic               latch_cause,
  input  logic               clear,
  output logic               any_req,
  output logic [IRQ_W-1:0]   cause,
  output logic [NUM_IRQ-1:0] ack
);

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] req;
  logic [IRQ_W-1:0]   cause_nxt;

  generate
    if (SYNC_IRQ != 0) begin : g_sync
      logic [NUM_IRQ-1:0] sync1;
      logic [NUM_IRQ-1:0] sync2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1 <= '0;
          sync2 <= '0;
        end else begin
          sync1 <= irq;
          sync2 <= sync1;
        end
      end
      assign irq_s = sync2;
    end else begin : g_nosync
      assign irq_s = irq;
    end
  endgenerate

  // The current mask gates the whole vector so a pending bit masked after it
  // latched can never fire; it stays pending until unmasked and taken.
  assign req     = (pending | irq_s) & imask;
  assign any_req = |req;
  assign ack     = NUM_IRQ'(1) << cause;

  always_comb begin
    cause_nxt = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (req[i-1]) cause_nxt = IRQ_W'(i - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      cause   <= '0;
    end else begin
      pending <= (pending | (irq_s & imask)) & ~(clear ? ack : '0);
      if (latch_cause) cause <= cause_nxt;
    end
  end

endmodule

// File: rtl/otter_cu_fsm_mc.sv
// Multicycle OTTER control FSM with a variable-latency memory handshake and
// prioritised, masked interrupt entry at instruction boundaries.
module otter_cu_fsm_mc
  import otter_cu_pkg::*;
#(
  parameter int NUM_IRQ  = 4,
  parameter int SYNC_IRQ = 1,
  localparam int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               CU_CLK,
  input  logic               CU_RESET,
  input  logic [6:0]         CU_OPCODE,
  input  logic [2:0]         CU_FUNC3,
  input  logic [11:0]        CU_FUNC12,
  input  logic [NUM_IRQ-1:0] CU_IRQ,
  input  logic [NUM_IRQ-1:0] CU_IMASK,
  input  logic               CU_MIE,
  input  logic               CU_MEM_ACK,
  output logic               CU_PCWRITE,
  output logic               CU_REGWRITE,
  output logic               CU_MEMREAD1,
  output logic               CU_MEMREAD2,
  output logic               CU_MEMWRITE,
  output logic               CU_csrWrite,
  output logic               CU_mret,
  output logic               CU_intTaken,
  output logic [IRQ_W-1:0]   CU_intCause,
  output logic [NUM_IRQ-1:0] CU_intACK
);

  cu_state_t          state, state_nxt;
  opcode_t            opc;
  logic               end_instr, take, any_req, int_taken;
  logic               pcwrite, regwrite, memread1, memread2, memwrite, csr_write, mret;
  logic [IRQ_W-1:0]   cause;
  logic [NUM_IRQ-1:0] ack;

  assign opc  = opcode_t'(CU_OPCODE);
  assign take = CU_MIE & any_req;

  otter_irq_arbiter #(
    .NUM_IRQ  (NUM_IRQ),
    .SYNC_IRQ (SYNC_IRQ)
  ) u_irq_arbiter (
    .clk         (CU_CLK),
    .rst         (CU_RESET),
    .irq         (CU_IRQ),
    .imask       (CU_IMASK),
    .latch_cause (end_instr & take),
    .clear       (int_taken),
    .any_req     (any_req),
    .cause       (cause),
    .ack         (ack)
  );

  always_ff @(posedge CU_CLK or posedge CU_RESET) begin
    if (CU_RESET) state <= ST_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    end_instr = 1'b0;
    int_taken = 1'b0;
    pcwrite   = 1'b0;
    regwrite  = 1'b0;
    memread1  = 1'b0;
    memread2  = 1'b0;
    memwrite  = 1'b0;
    csr_write = 1'b0;
    mret      = 1'b0;
    case (state)
      ST_FETCH: begin
        memread1 = 1'b1;
        if (CU_MEM_ACK) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (opc)
          OPC_LOAD, OPC_STORE: state_nxt = ST_MEM;
          OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
            regwrite  = 1'b1;
            end_instr = 1'b1;
          end
          OPC_SYSTEM: begin
            regwrite  = (CU_FUNC3 != F3_PRIV);
            csr_write = is_csr_op(CU_FUNC3);
            mret      = (CU_FUNC3 == F3_PRIV) && (CU_FUNC12 == MRET_FUNC12);
            end_instr = 1'b1;
          end
          default: end_instr = 1'b1;
        endcase
      end
      ST_MEM: begin
        if (opc == OPC_LOAD) memread2 = 1'b1;
        else                 memwrite = 1'b1;
        if (CU_MEM_ACK) begin
          if (opc == OPC_LOAD) state_nxt = ST_WB;
          else                 end_instr = 1'b1;
        end
      end
      ST_WB: begin
        regwrite  = 1'b1;
        end_instr = 1'b1;
      end
      ST_INTER: begin
        int_taken = 1'b1;
        pcwrite   = 1'b1;
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
    if (end_instr) begin
      pcwrite   = 1'b1;
      state_nxt = take ? ST_INTER : ST_FETCH;
    end
  end

  // Outputs are forced low for the whole reset assertion, including mid-wait aborts
  assign CU_PCWRITE  = pcwrite   & ~CU_RESET;
  assign CU_REGWRITE = regwrite  & ~CU_RESET;
  assign CU_MEMREAD1 = memread1  & ~CU_RESET;
  assign CU_MEMREAD2 = memread2  & ~CU_RESET;
  assign CU_MEMWRITE = memwrite  & ~CU_RESET;
  assign CU_csrWrite = csr_write & ~CU_RESET;
  assign CU_mret     = mret      & ~CU_RESET;
  assign CU_intTaken = int_taken & ~CU_RESET;
  assign CU_intCause = (int_taken & ~CU_RESET) ? cause : '0;
  assign CU_intACK   = (int_taken & ~CU_RESET) ? ack   : '0;

endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// Directed bench for otter_cu_fsm_mc: per-cycle strobe checks against
// hand-derived expectations for fetch/mem latency, interrupts, CSR and reset.
module tb_otter_cu_fsm_mc;

  localparam logic [7:0] PCW  = 8'h80;
  localparam logic [7:0] RW   = 8'h40;
  localparam logic [7:0] MR1  = 8'h20;
  localparam logic [7:0] MR2  = 8'h10;
  localparam logic [7:0] MW   = 8'h08;
  localparam logic [7:0] CSR  = 8'h04;
  localparam logic [7:0] MRET = 8'h02;
  localparam logic [7:0] INT  = 8'h01;
  localparam logic [7:0] NONE = 8'h00;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011, OP_IMM = 7'b0010011, OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_SYS = 7'b1110011, OP_BAD = 7'b1111111;

  logic        CU_CLK = 1'b0;
  logic        CU_RESET;
  logic [6:0]  CU_OPCODE;
  logic [2:0]  CU_FUNC3;
  logic [11:0] CU_FUNC12;
  logic [3:0]  CU_IRQ, CU_IMASK;
  logic        CU_MIE, CU_MEM_ACK;
  logic        CU_PCWRITE, CU_REGWRITE, CU_MEMREAD1, CU_MEMREAD2, CU_MEMWRITE;
  logic        CU_csrWrite, CU_mret, CU_intTaken;
  logic [1:0]  CU_intCause;
  logic [3:0]  CU_intACK;
  logic [7:0]  outs;

  logic [6:0]  v_op  = OP_IMM;
  logic [2:0]  v_f3  = 3'b000;
  logic [11:0] v_f12 = 12'h000;
  logic [3:0]  v_irq = 4'b0000, v_mask = 4'b0000;
  logic        v_mie = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 CU_CLK = ~CU_CLK;

  otter_cu_fsm_mc #(
    .NUM_IRQ  (4),
    .SYNC_IRQ (1)
  ) dut (
    .CU_CLK      (CU_CLK),
    .CU_RESET    (CU_RESET),
    .CU_OPCODE   (CU_OPCODE),
    .CU_FUNC3    (CU_FUNC3),
    .CU_FUNC12   (CU_FUNC12),
    .CU_IRQ      (CU_IRQ),
    .CU_IMASK    (CU_IMASK),
    .CU_MIE      (CU_MIE),
    .CU_MEM_ACK  (CU_MEM_ACK),
    .CU_PCWRITE  (CU_PCWRITE),
    .CU_REGWRITE (CU_REGWRITE),
    .CU_MEMREAD1 (CU_MEMREAD1),
    .CU_MEMREAD2 (CU_MEMREAD2),
    .CU_MEMWRITE (CU_MEMWRITE),
    .CU_csrWrite (CU_csrWrite),
    .CU_mret     (CU_mret),
    .CU_intTaken (CU_intTaken),
    .CU_intCause (CU_intCause),
    .CU_intACK   (CU_intACK)
  );

  assign outs = {CU_PCWRITE, CU_REGWRITE, CU_MEMREAD1, CU_MEMREAD2,
                 CU_MEMWRITE, CU_csrWrite, CU_mret, CU_intTaken};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: apply staged stimulus at the falling edge, check strobes 1ns later
  task automatic step(input logic ack, input logic [7:0] exp, input string tag);
    @(negedge CU_CLK);
    CU_MEM_ACK = ack;
    CU_IRQ     = v_irq;
    CU_IMASK   = v_mask;
    CU_MIE     = v_mie;
    CU_OPCODE  = v_op;
    CU_FUNC3   = v_f3;
    CU_FUNC12  = v_f12;
    #1 check(tag, 32'(outs), 32'(exp));
  endtask

  task automatic inter(input logic [1:0] cause, input logic [3:0] ackv, input string tag);
    step(1'b0, PCW | INT, tag);
    check({tag, "_cause"}, 32'(CU_intCause), 32'(cause));
    check({tag, "_ack"}, 32'(CU_intACK), 32'(ackv));
  endtask

  // Single-cycle-fetch ALU-class instruction with the given expected EXEC strobes
  task automatic instr(input logic [7:0] exec_exp, input string tag);
    step(1'b1, MR1, {tag, "_fetch"});
    step(1'b0, exec_exp, {tag, "_exec"});
  endtask

  initial begin
    CU_RESET = 1'b1; CU_MEM_ACK = 1'b0; CU_IRQ = '0; CU_IMASK = '0; CU_MIE = 1'b0;
    CU_OPCODE = OP_IMM; CU_FUNC3 = '0; CU_FUNC12 = '0;

    @(negedge CU_CLK);
    #1 check("reset_outs", 32'(outs), 32'(NONE));
    check("reset_cause_ack", 32'({CU_intCause, CU_intACK}), 32'd0);

    // OP_IMM, fetch ACK after 3 wait cycles
    CU_RESET = 1'b0;
    #1 check("t1_fetch0", 32'(outs), 32'(MR1));
    step(1'b0, MR1, "t1_fetch1");
    step(1'b0, MR1, "t1_fetch2");
    step(1'b1, MR1, "t1_fetch3");
    step(1'b0, PCW | RW, "t1_exec");
    step(1'b0, MR1, "t1_refetch");

    // LOAD with 2 wait cycles in MEM; ACK during EXEC is ignored
    v_op = OP_LD;
    step(1'b1, MR1, "t2_ld_fetch");
    step(1'b1, NONE, "t2_ld_exec");
    step(1'b0, MR2, "t2_ld_mem0");
    step(1'b0, MR2, "t2_ld_mem1");
    step(1'b1, MR2, "t2_ld_mem2");
    step(1'b0, PCW | RW, "t2_ld_wb");
    v_op = OP_ST;
    step(1'b1, MR1, "t2_st_fetch");
    step(1'b0, NONE, "t2_st_exec");
    step(1'b0, MW, "t2_st_mem0");
    step(1'b1, MW | PCW, "t2_st_mem1");
    step(1'b0, MR1, "t2_st_refetch");

    // Two simultaneous IRQs pulsed for one cycle, taken lowest index first
    v_op = OP_ALU; v_mie = 1'b1; v_mask = 4'b1111; v_irq = 4'b1010;
    step(1'b0, MR1, "t3_fetch_a");
    v_irq = 4'b0000;
    step(1'b1, MR1, "t3_fetch_b");
    step(1'b0, PCW | RW, "t3_exec1");
    inter(2'd1, 4'b0010, "t3_int1");
    instr(PCW | RW, "t3_i2");
    inter(2'd3, 4'b1000, "t3_int3");
    instr(PCW | RW, "t3_i3");
    step(1'b0, MR1, "t3_no_int");

    // IRQ[2] held while MIE=0: latched but not taken until MIE rises
    v_mie = 1'b0; v_irq = 4'b0100; v_op = OP_IMM;
    for (int i = 0; i < 10; i++) instr(PCW | RW, $sformatf("t4_mie0_%0d", i));
    v_mie = 1'b1; v_irq = 4'b0000;
    instr(PCW | RW, "t4_mie1");
    inter(2'd2, 4'b0100, "t4_int2");
    instr(PCW | RW, "t4_after");
    step(1'b0, MR1, "t4_no_reint");
    // Same source masked: never taken
    v_mask = 4'b1011; v_irq = 4'b0100;
    for (int i = 0; i < 3; i++) instr(PCW | RW, $sformatf("t4_masked_%0d", i));
    step(1'b0, MR1, "t4_masked_no_int");
    v_irq = 4'b0000;

    // SYSTEM decode and unrecognised opcodes
    v_mie = 1'b0; v_op = OP_SYS;
    v_f3 = 3'b001; v_f12 = 12'h340;
    instr(PCW | RW | CSR, "t5_csrrw");
    v_f3 = 3'b111;
    instr(PCW | RW | CSR, "t5_csrrci");
    v_f3 = 3'b100;
    instr(PCW | RW, "t5_f3_100");
    v_f3 = 3'b000; v_f12 = 12'h302;
    instr(PCW | MRET, "t5_mret");
    v_f12 = 12'h000;
    instr(PCW, "t5_ecall");
    v_op = OP_BAD;
    instr(PCW, "t5_bad_op");
    v_op = OP_BR;
    instr(PCW, "t5_branch");
    v_op = OP_LUI;
    instr(PCW | RW, "t5_lui");

    // Reset during a STORE wait with a pending interrupt latched
    v_mask = 4'b1111; v_irq = 4'b0001; v_op = OP_ST;
    step(1'b1, MR1, "t6_fetch");
    v_irq = 4'b0000;
    step(1'b0, NONE, "t6_exec");
    step(1'b0, MW, "t6_mem0");
    step(1'b0, MW, "t6_mem1");
    @(negedge CU_CLK);
    CU_RESET = 1'b1;
    #1 check("t6_rst_outs", 32'(outs), 32'(NONE));
    check("t6_rst_cause_ack", 32'({CU_intCause, CU_intACK}), 32'd0);
    v_mie = 1'b1; v_op = OP_IMM;
    @(negedge CU_CLK);
    CU_RESET = 1'b0; CU_MEM_ACK = 1'b0; CU_MIE = 1'b1; CU_OPCODE = OP_IMM; CU_IRQ = '0;
    #1 check("t6_release", 32'(outs), 32'(MR1));
    step(1'b0, MR1, "t6_fetch_wait");
    step(1'b1, MR1, "t6_fetch_ack");
    step(1'b0, PCW | RW, "t6_exec_imm");
    step(1'b0, MR1, "t6_no_int");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
